mul_scheduler: RTL
==================

Name: mul_scheduler

Overview:
Shares one radix-8 Booth multiplier core (32x32 signed operands, 67-bit sign-extended product, start/done handshake) among NREQ requesters. Requesters are served one at a time in round-robin order. The block latches the winner's operands, pulses the core's start and waits for done, with a watchdog. It then returns the product to the winning requester through a valid/ready handshake. It sits between the ALU issue logic and the multiplier core.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before the operation is aborted with error (must be ≥ 20)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  request pending, one bit per requester
req_x  in  NREQ*32  multiplicand per requester; requester i uses bits [32i+31:32i]
req_y  in  NREQ*32  multiplier per requester; same packing as req_x
req_ready  out  NREQ  one-hot accept strobe
mul_start  out  1  one-cycle start pulse to the core
mul_x  out  32  operand X to the core, held stable from ISSUE until leaving WAIT
mul_y  out  32  operand Y to the core, held stable from ISSUE until leaving WAIT
mul_done  in  1  core completion pulse
mul_product  in  67  core result, valid when mul_done=1
resp_valid  out  NREQ  one-hot response valid
resp_ready  in  NREQ  response accept, per requester
resp_product  out  67  captured product (0 on error)
resp_err  out  1  response is a watchdog abort
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; rr pointer=0; all registered outputs 0: mul_x, mul_y, resp_product, resp_err, mul_start; req_ready=0; resp_valid=0; busy=0. Reset mid-operation discards the operation; no response is issued; a later mul_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - When any req_valid is set, grant the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - req_ready[g]=1 in that same cycle (combinational from state and req_valid); the handshake completes that cycle.
  - Latch req_x/req_y slice g into mul_x/mul_y; latch id=g; set the rr pointer to (g+1) mod NREQ; go to ISSUE.
  - With no request, req_ready=0.
- ISSUE: mul_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT. mul_done during ISSUE is ignored.
- WAIT:
  - If mul_done=1: capture mul_product into resp_product; resp_err=0; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without done: resp_product=0; resp_err=1; go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - resp_valid[id]=1; resp_product and resp_err are held.
  - When resp_ready[id]=1, return to IDLE the next cycle. No new grant is made in the RESP cycle.
  - resp_ready bits of other requesters are ignored.
- Latency: accept at cycle t → mul_start at t+1. With mul_done at cycle d, resp_valid is first asserted at d+1. Minimum gap between two accepts is 4 cycles.
- req_valid deasserted after the grant has no effect. Operands are not re-read after IDLE.
- A requester holding req_valid continuously cannot starve the others, because the rr pointer always advances past the last grant.

Decomposition:
- Package mul_sched_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, RESP);
  - OP_W=32 and PROD_W=67;
  - the clog2-based id width.
- One sub-module, rr_arbiter:
  - purely combinational;
  - inputs req_valid and rr pointer;
  - outputs one-hot grant and grant index.
- The scheduler FSM, operand and response registers, and watchdog stay in mul_scheduler.

Test Plan:
- Single multiply: req_valid=01, x=2, y=3; core returns done after 12 cycles with product 6 → req_ready=01 same cycle; mul_start pulse one cycle later; resp_valid=01 with resp_product=67'd6, resp_err=0.
- Signed operands: x=-5 (0xFFFFFFFB), y=7 → resp_product = -35 sign-extended to 67 bits (all ones except the low bits of 0x...FDD).
- Contention: req_valid=11 held continuously, resp_ready=11 → grants alternate 01, 10, 01, 10. Each accept is followed by exactly one matching response.
- Backpressure: resp_ready held 0 for 10 cycles in RESP → resp_valid and resp_product stay stable, busy=1, no new req_ready. Release → IDLE next cycle.
- Watchdog: mul_done never asserted, TIMEOUT=64 → resp_valid with resp_err=1, resp_product=0. mul_done arriving in the same cycle as the timeout yields resp_err=0.
- Reset mid-WAIT: assert rst asynchronously 5 cycles after mul_start → all outputs 0 immediately. A stale mul_done afterwards produces no response, and the next request is served normally.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared constants for the multiplier scheduler: operand/product widths,
// requester id width and FSM state encoding.
package mul_sched_pkg;

  localparam int OP_W     = 32;
  localparam int PROD_W   = 67;
  localparam int MAX_NREQ = 8;
  localparam int ID_W     = $clog2(MAX_NREQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Requester index following g, wrapping modulo n.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] g, input int n);
    return (int'(g) == n - 1) ? '0 : g + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or above the
// pointer, wrapping modulo NREQ.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                idx;

  always_comb begin
    dbl       = {req_valid, req_valid} >> rr_ptr;
    rot       = dbl[NREQ-1:0];
    idx       = 0;
    grant_any = 1'b0;
    grant     = '0;
    // rot[k] is requester (rr_ptr + k) mod NREQ
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && rot[k]) begin
        grant_any = 1'b1;
        idx       = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      grant[j] = grant_any && (j == idx);
    end
    grant_idx = ID_W'(idx);
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one multiplier core among NREQ requesters in round-robin order,
// with a watchdog on the core's done pulse and a valid/ready response.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*OP_W-1:0]     req_x,
  input  logic [NREQ*OP_W-1:0]     req_y,
  output logic [NREQ-1:0]          req_ready,
  output logic                     mul_start,
  output logic signed [OP_W-1:0]   mul_x,
  output logic signed [OP_W-1:0]   mul_y,
  input  logic                     mul_done,
  input  logic signed [PROD_W-1:0] mul_product,
  output logic [NREQ-1:0]          resp_valid,
  input  logic [NREQ-1:0]          resp_ready,
  output logic signed [PROD_W-1:0] resp_product,
  output logic                     resp_err,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [1:0]             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        id;
  logic [CNT_W-1:0]       wd_cnt;
  logic [NREQ-1:0]        grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any;
  logic signed [OP_W-1:0] x_sel;
  logic signed [OP_W-1:0] y_sel;
  logic                   resp_acc;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        x_sel = req_x[i*OP_W +: OP_W];
        y_sel = req_y[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state == ST_RESP) begin
      for (int i = 0; i < NREQ; i++) begin
        resp_valid[i] = (id == ID_W'(i));
      end
    end
  end

  // Only the winner's ready bit can complete the response.
  assign resp_acc  = |(resp_valid & resp_ready);
  assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      id           <= '0;
      wd_cnt       <= '0;
      mul_start    <= 1'b0;
      mul_x        <= '0;
      mul_y        <= '0;
      resp_product <= '0;
      resp_err     <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            mul_x     <= x_sel;
            mul_y     <= y_sel;
            id        <= grant_idx;
            rr_ptr    <= next_id(grant_idx, NREQ);
            mul_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes priority over a same-cycle timeout
          if (mul_done) begin
            resp_product <= mul_product;
            resp_err     <= 1'b0;
            state        <= ST_RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_product <= '0;
            resp_err     <= 1'b1;
            state        <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_acc) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
